// File: rtl/prio_grant_pkg.sv
// prio_grant_pkg: shared state encoding, mode constants and width helper for the grant arbiter
package prio_grant_pkg;

    typedef logic [0:0] state_t;

    localparam state_t ST_IDLE  = 1'b0;
    localparam state_t ST_GRANT = 1'b1;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Index width that never collapses to zero bits
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// priority_encoder_n: finds the first set bit searching upward from a rotate offset, wrapping at N
module priority_encoder_n
    import prio_grant_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic [N-1:0]     vec,
    input  logic [IDX_W-1:0] offset,
    output logic             found,
    output logic [IDX_W-1:0] idx
);

    logic [IDX_W-1:0] pos;

    // Walk the search order backwards so the earliest position in the order wins
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int j = N - 1; j >= 0; j--) begin
            pos = IDX_W'((int'(offset) + j) % N);
            if (vec[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/prio_grant_fsm.sv
// prio_grant_fsm: registered N-way arbiter holding each grant until ack, fixed-priority or round-robin
module prio_grant_fsm
    import prio_grant_pkg::*;
#(
    parameter int N = 4,
    localparam int IDX_W = clog2_min1(N)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic             mode,
    input  logic             ack,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    output logic [N-1:0]     grant_onehot,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [N-1:0]     rev, mask, enc_vec;
    logic [IDX_W-1:0] enc_off, enc_idx, win;
    logic             enc_found, ackd, rr;

    // Fixed priority reuses the upward search by bit-reversing req, so the highest index comes first
    for (genvar g = 0; g < N; g++) begin : g_rev
        assign rev[g] = req[N - 1 - g];
    end

    priority_encoder_n #(.N(N)) u_enc (
        .vec    (enc_vec),
        .offset (enc_off),
        .found  (enc_found),
        .idx    (enc_idx)
    );

    // Next-state: arbitrate from IDLE or on an accepted ack, otherwise hold the locked grant
    always_comb begin
        ackd    = (state_q == ST_GRANT) && ack;
        rr      = (mode == MODE_RR);
        last_d  = ackd ? idx_q : last_q;
        mask    = (ackd && rr) ? (N'(1) << idx_q) : '0;
        enc_vec = rr ? (req & ~mask) : rev;
        enc_off = rr ? ((last_d == IDX_W'(N - 1)) ? '0 : last_d + IDX_W'(1)) : '0;
        win     = rr ? enc_idx : IDX_W'(N - 1) - enc_idx;
        state_d = state_q;
        idx_d   = idx_q;
        if ((state_q == ST_IDLE) || ackd) begin
            state_d = enc_found ? ST_GRANT : ST_IDLE;
            idx_d   = enc_found ? win : idx_q;
        end
    end

    // State registers; reset drops any grant and re-aims round-robin at channel 0
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            last_q  <= IDX_W'(N - 1);
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
        end
    end

    assign busy         = (state_q == ST_GRANT);
    assign grant_valid  = busy;
    assign grant_idx    = idx_q;
    assign grant_onehot = busy ? (N'(1) << idx_q) : '0;

endmodule

// File: tb/tb_prio_grant_fsm.sv
// tb_prio_grant_fsm: table vectors, directed corner sequences and randomized model comparison
module tb_prio_grant_fsm;

    localparam int N = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic       mode  = 1'b0;
    logic       ack   = 1'b0;
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [3:0] grant_onehot;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // behavioural model state
    bit m_valid = 0;
    int m_idx   = 0;
    int m_last  = N - 1;

    prio_grant_fsm #(.N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .req          (req),
        .mode         (mode),
        .ack          (ack),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .busy         (busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       mode;
        logic       ack;
        logic       v;
        int         idx;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    task automatic exp_out(input string name, input bit v, input int idx, input bit chk_idx);
        chk({name, ".valid"}, int'(grant_valid), int'(v));
        chk({name, ".busy"}, int'(busy), int'(v));
        chk({name, ".onehot"}, int'(grant_onehot), v ? (1 << idx) : 0);
        if (chk_idx) chk({name, ".idx"}, int'(grant_idx), idx);
    endtask

    task automatic model_update(input bit r, input logic [3:0] q, input bit m, input bit a);
        int w, masked, c;
        if (r) begin
            m_valid = 0;
            m_idx   = 0;
            m_last  = N - 1;
        end else if (!m_valid || a) begin
            masked = -1;
            if (m_valid) begin
                m_last = m_idx;
                if (m) masked = m_idx;
            end
            w = -1;
            if (!m) begin
                for (int i = 0; i < N; i++) if (q[i]) w = i;
            end else begin
                for (int s = 1; s <= N; s++) begin
                    c = (m_last + s) % N;
                    if (w < 0 && q[c] && c != masked) w = c;
                end
            end
            m_valid = (w >= 0);
            if (w >= 0) m_idx = w;
        end
    endtask

    task automatic step(input bit r, input logic [3:0] q, input bit m, input bit a);
        reset = r;
        req   = q;
        mode  = m;
        ack   = a;
        @(posedge clock);
        model_update(r, q, m, a);
        #1;
    endtask

    initial begin
        tbl = '{
            '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0},
            '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0},
            '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0},
            '{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 0},
            '{1'b0, 4'b1010, 1'b0, 1'b0, 1'b1, 3},
            '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 3},
            '{1'b0, 4'b0010, 1'b0, 1'b0, 1'b1, 3},
            '{1'b0, 4'b0010, 1'b0, 1'b1, 1'b1, 1},
            '{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 0},
            '{1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 0},
            '{1'b0, 4'b1111, 1'b1, 1'b0, 1'b1, 0},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 1},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 2},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 3},
            '{1'b0, 4'b1111, 1'b1, 1'b1, 1'b1, 0},
            '{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 0},
            '{1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 0}
        };
        for (int i = 0; i < 17; i++) begin
            step(tbl[i].rst, tbl[i].req, tbl[i].mode, tbl[i].ack);
            exp_out($sformatf("tbl%0d", i), tbl[i].v, tbl[i].idx, tbl[i].v || tbl[i].rst);
        end

        // round-robin wrap past channel 3 and masking of the just-acked channel
        step(1, 4'b0000, 1, 0);
        step(0, 4'b0100, 1, 0); exp_out("rr_first2", 1, 2, 1);
        step(0, 4'b0101, 1, 1); exp_out("rr_wrap0", 1, 0, 1);
        step(0, 4'b0001, 1, 1); exp_out("rr_mask_idle", 0, 0, 0);
        step(0, 4'b0001, 1, 0); exp_out("rr_regrant0", 1, 0, 1);

        // reset mid-grant wins over a simultaneous ack, grant is never revoked by dropping req
        step(1, 4'b0000, 1, 0);
        step(0, 4'b0100, 1, 0); exp_out("mid_grant2", 1, 2, 1);
        step(0, 4'b0000, 1, 0); exp_out("mid_lock", 1, 2, 1);
        step(1, 4'b1111, 1, 1); exp_out("mid_reset", 0, 0, 1);
        step(0, 4'b1111, 1, 0); exp_out("mid_after", 1, 0, 1);

        // mode switch while a fixed-priority grant is held
        step(1, 4'b0000, 0, 0);
        step(0, 4'b1000, 0, 0); exp_out("mode_g3", 1, 3, 1);
        step(0, 4'b1001, 1, 0); exp_out("mode_hold", 1, 3, 1);
        step(0, 4'b1001, 1, 1); exp_out("mode_rr0", 1, 0, 1);

        // ack while idle is ignored and leaves round-robin pointer untouched
        step(1, 4'b0000, 1, 0);
        step(0, 4'b0000, 1, 1); exp_out("idle_ack", 0, 0, 0);
        step(0, 4'b0010, 1, 1); exp_out("idle_ack_grant", 1, 1, 1);

        // randomized traffic against the behavioural model
        step(1, 4'b0000, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            bit r, m, a;
            r = ($urandom_range(63) == 0);
            m = (i % 400 < 200) ? ($urandom_range(7) != 0) : ($urandom_range(7) == 0);
            a = $urandom_range(1) == 1;
            step(r, 4'($urandom_range(15)), m, a);
            exp_out("rand", m_valid, m_idx, m_valid);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
